// File: rtl/wb_arbiter_2m.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2m
//   Two-master, one-slave Wishbone arbiter. m0 is the host controller, m1 is
//   the core. A three-state FSM (IDLE / GRANT0 / GRANT1) owns the slave bus;
//   ties from IDLE go to the master that did not hold the bus last. The
//   granted master keeps the bus for as long as it holds cyc, and on release
//   the bus is handed straight to a waiting master without an idle cycle.
//
//   Optional stall watchdog: define WB_ARB_TIMEOUT_EN. When enabled, a
//   counter tracks cycles with s_stb_o high and no s_ack_i. On reaching
//   TIMEOUT_CYCLES the granted master gets a one-cycle err pulse, the slave
//   cycle is dropped that cycle, and the FSM returns to IDLE. Without the
//   macro there is no counter and both err outputs are tied low.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   m0_*_i / m1_*_i           master requests: cyc, stb, we, addr, data
//   m0_data_o / m1_data_o     read data (both driven from s_data_i)
//   m0_ack_o / m1_ack_o       acknowledge, granted master only
//   m0_err_o / m1_err_o       watchdog timeout pulse
//   s_cyc_o .. s_data_o       slave-side request, muxed from granted master
//   s_data_i, s_ack_i         slave read data and acknowledge
//   grant_o                   registered one-hot grant {m1,m0}, 00 when idle
// ---------------------------------------------------------------------------
module wb_arbiter_2m #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;   // 0: m0 held the bus last, 1: m1 held it last
  logic   timeout;      // watchdog fired this cycle

  // Unmasked request of the granted master
  logic                  sel_cyc;
  logic                  sel_stb;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    sel_cyc  = 1'b0;
    sel_stb  = 1'b0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    case (state)
      GRANT0: begin
        sel_cyc  = m0_cyc_i;
        sel_stb  = m0_stb_i;
        sel_we   = m0_we_i;
        sel_addr = m0_addr_i;
        sel_data = m0_data_i;
      end
      GRANT1: begin
        sel_cyc  = m1_cyc_i;
        sel_stb  = m1_stb_i;
        sel_we   = m1_we_i;
        sel_addr = m1_addr_i;
        sel_data = m1_data_i;
      end
      default: ;
    endcase
  end

  // The watchdog cycle kills cyc/stb so the slave sees the transfer abandoned
  assign s_cyc_o  = sel_cyc & ~timeout;
  assign s_stb_o  = sel_stb & ~timeout;
  assign s_we_o   = sel_we;
  assign s_addr_o = sel_addr;
  assign s_data_o = sel_data;

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  // Acks gated by the current grant, so an ack arriving in IDLE goes nowhere
  assign m0_ack_o = s_ack_i & (state == GRANT0) & ~timeout;
  assign m1_ack_o = s_ack_i & (state == GRANT1) & ~timeout;

  assign m0_err_o = timeout & (state == GRANT0);
  assign m1_err_o = timeout & (state == GRANT1);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             release_bus;

  assign timeout = (state != IDLE) && (stall_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Any way out of a grant state counts as a grant change
  assign release_bus = timeout ||
                       ((state == GRANT0) && !m0_cyc_i) ||
                       ((state == GRANT1) && !m1_cyc_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) || release_bus || s_ack_i) begin
      stall_cnt <= '0;
    end else if (sel_stb) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_o    <= 2'b00;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the master that did not own the bus last wins
          if (m0_cyc_i && (!m1_cyc_i || last_grant)) begin
            state   <= GRANT0;
            grant_o <= 2'b01;
          end else if (m1_cyc_i) begin
            state   <= GRANT1;
            grant_o <= 2'b10;
          end
        end
        GRANT0: begin
          if (timeout) begin
            state      <= IDLE;
            grant_o    <= 2'b00;
            last_grant <= 1'b0;
          end else if (!m0_cyc_i) begin
            last_grant <= 1'b0;
            if (m1_cyc_i) begin
              state   <= GRANT1;
              grant_o <= 2'b10;
            end else begin
              state   <= IDLE;
              grant_o <= 2'b00;
            end
          end
        end
        GRANT1: begin
          if (timeout) begin
            state      <= IDLE;
            grant_o    <= 2'b00;
            last_grant <= 1'b1;
          end else if (!m1_cyc_i) begin
            last_grant <= 1'b1;
            if (m0_cyc_i) begin
              state   <= GRANT0;
              grant_o <= 2'b01;
            end else begin
              state   <= IDLE;
              grant_o <= 2'b00;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_2m
//   Directed bench for wb_arbiter_2m: single-master read, simultaneous
//   request tie and direct handoff, multi-beat hold, mid-transfer reset, and
//   the stall watchdog (WB_ARB_TIMEOUT_EN) or indefinite hold without it.
// ---------------------------------------------------------------------------
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_ack_i;
  logic [1:0]  grant_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_cyc_i (m0_cyc_i),
    .m0_stb_i (m0_stb_i),
    .m0_we_i  (m0_we_i),
    .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i),
    .m0_data_o(m0_data_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_we_i  (m1_we_i),
    .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i),
    .m1_data_o(m1_data_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_data_i (s_data_i),
    .s_ack_i  (s_ack_i),
    .grant_o  (grant_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_data_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_data_i = '0;
    s_ack_i  = 0; s_data_i = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled at the falling edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    clr();

    // Reset state
    smp();
    check("rst_grant", grant_o, 2'b00);
    check("rst_scyc", s_cyc_o, 0);
    check("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
    nxt();
    rst = 1'b0;

    // Single master read with delayed slave ack
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_addr_i = 32'h0000_0010;
    smp();
    check("rd_lat_grant", grant_o, 2'b00);
    check("rd_lat_scyc", s_cyc_o, 0);
    nxt();
    smp();
    check("rd_grant", grant_o, 2'b01);
    check("rd_scyc", s_cyc_o, 1);
    check("rd_saddr", s_addr_o, 32'h0000_0010);
    check("rd_swe", s_we_o, 0);
    nxt();
    nxt();
    s_ack_i = 1; s_data_i = 32'hDEAD_BEEF;
    smp();
    check("rd_m0ack", m0_ack_o, 1);
    check("rd_m0data", m0_data_o, 32'hDEAD_BEEF);
    check("rd_m1ack", m1_ack_o, 0);
    nxt();
    clr();
    nxt();
    s_ack_i = 1;
    smp();
    check("idle_grant", grant_o, 2'b00);
    check("idle_ack_ignored", {m0_ack_o, m1_ack_o}, 2'b00);
    check("idle_scyc", s_cyc_o, 0);
    s_ack_i = 0;

    // Tie after reset goes to m0, then direct handoff to m1
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h20;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h30;
    nxt();
    smp();
    check("tie_grant", grant_o, 2'b01);
    check("tie_saddr", s_addr_o, 32'h20);
    nxt();
    m0_cyc_i = 0; m0_stb_i = 0;
    smp();
    check("rel_grant_held", grant_o, 2'b01);
    check("rel_scyc", s_cyc_o, 0);
    nxt();
    smp();
    check("handoff_grant", grant_o, 2'b10);
    check("handoff_saddr", s_addr_o, 32'h30);
    check("handoff_scyc", s_cyc_o, 1);

    // m1 holds the bus across four write beats while m0 waits
    nxt();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h40;
    for (int i = 0; i < 4; i++) begin
      m1_we_i = 1; m1_addr_i = 32'h100 + 32'(4 * i); m1_data_i = 32'hA0 + 32'(i);
      s_ack_i = 1;
      smp();
      check("beat_grant", grant_o, 2'b10);
      check("beat_m1ack", m1_ack_o, 1);
      check("beat_m0ack", m0_ack_o, 0);
      check("beat_saddr", s_addr_o, 32'h100 + 32'(4 * i));
      check("beat_sdata", s_data_o, 32'hA0 + 32'(i));
      check("beat_swe", s_we_o, 1);
      nxt();
    end
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; s_ack_i = 0;
    smp();
    check("beats_done_grant", grant_o, 2'b10);
    nxt();
    smp();
    check("m0_after_m1", grant_o, 2'b01);
    check("m0_after_m1_addr", s_addr_o, 32'h40);

    // Reset during an m1 transfer; last_grant was m0 before reset
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    nxt();
    smp();
    check("pre_rst_g0", grant_o, 2'b01);
    nxt();
    m0_cyc_i = 0; m0_stb_i = 0;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h50;
    nxt();
    smp();
    check("pre_rst_g1", grant_o, 2'b10);
    nxt();
    s_ack_i = 1;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_scyc", s_cyc_o, 0);
    check("mid_rst_grant", grant_o, 2'b00);
    check("mid_rst_ackerr", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
    clr();
    nxt();
    rst = 1'b0;
    m0_cyc_i = 1; m0_stb_i = 1;
    m1_cyc_i = 1; m1_stb_i = 1;
    smp();
    check("post_rst_idle", grant_o, 2'b00);
    nxt();
    smp();
    check("post_rst_tie_m0", grant_o, 2'b01);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks m0; m1 is waiting
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    m1_cyc_i = 1; m1_stb_i = 1;
    nxt();
    for (int i = 0; i < 8; i++) begin
      smp();
      check("stall_grant", grant_o, 2'b01);
      check("stall_noerr", m0_err_o, 0);
      nxt();
    end
    smp();
    check("to_m0err", m0_err_o, 1);
    check("to_m1err", m1_err_o, 0);
    check("to_scyc", s_cyc_o, 0);
    check("to_sstb", s_stb_o, 0);
    nxt();
    smp();
    check("to_idle", grant_o, 2'b00);
    check("to_err_pulse", m0_err_o, 0);
    nxt();
    smp();
    check("to_m1_next", grant_o, 2'b10);
`else
    // Without the watchdog a stalled grant is held indefinitely
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    nxt();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      smp();
      if (grant_o !== 2'b01 || m0_err_o !== 1'b0 || m1_err_o !== 1'b0) bad++;
      nxt();
    end
    check("hold_bad_cycles", 64'(bad), 0);
    smp();
    check("hold_grant", grant_o, 2'b01);
    check("hold_scyc", s_cyc_o, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, stalled-cycle limit before forced termination.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 m0_cyc_i, m1_cyc_i  in  1  master cycle request (m0 = host controller, m1 = core).
REQ-007 m0_stb_i, m1_stb_i  in  1  master strobe.
REQ-008 m0_we_i, m1_we_i  in  1  master write enable.
REQ-009 m0_addr_i, m1_addr_i  in  ADDR_WIDTH  master address.
REQ-010 m0_data_i, m1_data_i  in  DATA_WIDTH  master write data.
REQ-011 m0_data_o, m1_data_o  out  DATA_WIDTH  read data, both driven from s_data_i.
REQ-012 m0_ack_o, m1_ack_o  out  1  acknowledge, granted master only.
REQ-013 m0_err_o, m1_err_o  out  1  timeout error pulse.
REQ-014 s_cyc_o, s_stb_o, s_we_o  out  1  slave-side cycle, strobe and write enable.
REQ-015 s_addr_o  out  ADDR_WIDTH, s_data_o  out  DATA_WIDTH  slave-side address and write data.
REQ-016 s_data_i  in  DATA_WIDTH, s_ack_i  in  1  slave read data and acknowledge.
REQ-017 grant_o  out  2  one-hot registered grant {m1,m0}; 00 when idle.

Function
REQ-018 FSM SHALL have states IDLE, GRANT0, GRANT1; grant_o SHALL equal 01 in GRANT0, 10 in GRANT1, 00 in IDLE.
REQ-019 IDLE: one requester -> its GRANT state next cycle; both requesting -> master not in last_grant register wins; none -> stay.
REQ-020 Grant latency SHALL be exactly one cycle from mX_cyc_i rising to s_cyc_o rising.
REQ-021 In GRANTx, s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_data_o SHALL combinationally follow master x; in IDLE all SHALL be 0.
REQ-022 mX_ack_o SHALL equal s_ack_i AND (grant is x); non-granted master ack SHALL be 0.
REQ-023 Grant SHALL be held while granted master keeps cyc_i high, including across multiple stb/ack beats.
REQ-024 Granted cyc_i low: if other master's cyc_i high, SHALL move directly to other GRANT state next cycle, else IDLE; last_grant SHALL update to released master.
REQ-025 Requests SHALL be level-sensitive; a master dropping cyc_i before grant SHALL lose its request without side effect.
REQ-026 s_ack_i while IDLE SHALL be ignored.

Reset
REQ-027 rst high SHALL immediately force IDLE, grant_o=00, all s_ control outputs 0, all ack/err 0, last_grant=m1 (m0 wins first tie), timeout counter 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it with no ack or err to either master.

Configuration
REQ-029 Macro WB_ARB_TIMEOUT_EN SHALL compile in a stall watchdog.
REQ-030 With WB_ARB_TIMEOUT_EN: counter increments each cycle s_stb_o=1 and s_ack_i=0, clears on ack or grant change; on reaching TIMEOUT_CYCLES, mX_err_o of granted master SHALL pulse one cycle, s_cyc_o/s_stb_o SHALL be 0 that cycle, FSM SHALL go IDLE with last_grant = timed-out master.
REQ-031 Without WB_ARB_TIMEOUT_EN: no counter, m0_err_o=m1_err_o=0 constantly, grant held indefinitely.

Verification
REQ-032 m0 read addr 0x00000010 alone, slave acks data 0xDEADBEEF after 3 cycles -> grant_o=01 one cycle after cyc, m0_ack_o=1 with m0_data_o=0xDEADBEEF, m1_ack_o=0.
REQ-033 m0 and m1 raise cyc same cycle after reset -> GRANT0 first; m0 releases -> GRANT1 next cycle with no IDLE cycle.
REQ-034 m1 holds cyc for 4 write beats (0x100..0x10C) while m0 requests -> grant_o stays 10 for all beats, m0 granted only after m1 drops cyc.
REQ-035 rst pulsed mid-transfer in GRANT1 -> s_cyc_o=0 same cycle, grant_o=00, no ack/err; next tie grants m0.
REQ-036 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks m0 -> m0_err_o pulses one cycle after 8 stalled cycles, FSM IDLE, pending m1 granted next; without macro, grant_o=01 held for 1000 cycles and err stays 0.
